// File: rtl/rgb_fade_pkg.sv
// rtl/rgb_fade_pkg.sv - shared encodings and constants for the RGB fade controller
// Contents: mode encoding (mode_t), wheel phase encoding (phase_t), duty_max()
// helper, 16-entry gamma table and lookup function used when FADE_GAMMA_EN is defined.
package rgb_fade_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_WHEEL   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_STATIC  = 2'd3
  } mode_t;

  // Wheel phases: which channel moves and in which direction.
  typedef enum logic [2:0] {
    PH_G_UP   = 3'd0,
    PH_R_DOWN = 3'd1,
    PH_B_UP   = 3'd2,
    PH_G_DOWN = 3'd3,
    PH_R_UP   = 3'd4,
    PH_B_DOWN = 3'd5
  } phase_t;

  function automatic int duty_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Index 15 sits in the most significant slot: entries 0..15 are
  // 0,0,0,1,1,2,2,3,4,5,6,7,9,11,13,15.
  localparam logic [15:0][3:0] GAMMA_LUT = {
    4'd15, 4'd13, 4'd11, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4,
    4'd3,  4'd2,  4'd2,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0
  };

  function automatic logic [3:0] gamma_lut(input logic [3:0] lvl);
    return GAMMA_LUT[lvl];
  endfunction

endpackage

// File: rtl/fade_tick_gen.sv
// rtl/fade_tick_gen.sv - fade step prescaler, one tick every TICK_DIV clocks
// Ports: clk, reset (async, active high), hold (freeze count, suppress tick),
// clear (restart count from 0), tick (high while count == TICK_DIV-1 and not held).
module fade_tick_gen #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  assign tick = ~hold & (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold) begin
      count <= (count == LAST) ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/rgb_fade_ctrl.sv
// rtl/rgb_fade_ctrl.sv - three-channel LED fade pattern generator (OFF/WHEEL/BREATHE/STATIC)
// Ports: clk, reset (async, active high), mode_btn (debounced mode advance),
// hold (freeze pattern), duty_r/duty_g/duty_b (DUTY_W-bit duty codes),
// step (one-cycle pulse with each tick-driven duty update), mode (current mode).
// Config macro: FADE_GAMMA_EN routes each level through the 16-entry gamma
// table before the output register (requires DUTY_W = 4).
module rgb_fade_ctrl
  import rgb_fade_pkg::*;
#(
  parameter int TICK_DIV = 2500000,
  parameter int DUTY_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              hold,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic              step,
  output logic [1:0]        mode
);

  localparam logic [DUTY_W-1:0] DMAX    = DUTY_W'(duty_max(DUTY_W));
  localparam logic [DUTY_W-1:0] ONE     = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] DMAX_M1 = DMAX - ONE;

  mode_t             mode_q, mode_d;
  phase_t            phase_q, phase_d;
  logic              dir_up_q, dir_up_d;
  logic [DUTY_W-1:0] r_q, g_q, b_q;
  logic [DUTY_W-1:0] r_d, g_d, b_d;
  logic              btn_prev_q;
  logic              primed_q;
  logic              tick_q;
  logic              tick;
  logic              btn_edge;
  logic              tick_take;

  // primed_q stays low for the first edge after reset so a button held
  // through reset is absorbed into btn_prev_q instead of seen as a press.
  assign btn_edge  = primed_q & mode_btn & ~btn_prev_q;
  assign tick_take = tick & ~btn_edge;
  assign mode      = mode_q;

  fade_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .hold (hold),
    .clear(btn_edge),
    .tick (tick)
  );

  always_comb begin
    mode_d   = mode_q;
    phase_d  = phase_q;
    dir_up_d = dir_up_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    if (btn_edge) begin
      phase_d  = PH_G_UP;
      dir_up_d = 1'b1;
      case (mode_q)
        MODE_OFF: begin
          mode_d = MODE_WHEEL;
          r_d    = DMAX;
          g_d    = '0;
          b_d    = '0;
        end
        MODE_WHEEL: begin
          mode_d = MODE_BREATHE;
          r_d    = '0;
          g_d    = '0;
          b_d    = '0;
        end
        MODE_BREATHE: begin
          mode_d = MODE_STATIC;
          r_d    = DMAX;
          g_d    = DMAX;
          b_d    = DMAX;
        end
        default: begin
          mode_d = MODE_OFF;
          r_d    = '0;
          g_d    = '0;
          b_d    = '0;
        end
      endcase
    end else if (tick) begin
      case (mode_q)
        MODE_WHEEL: begin
          // The tick that lands the active channel on its target also
          // moves to the next phase.
          case (phase_q)
            PH_G_UP: begin
              g_d = g_q + ONE;
              if (g_q == DMAX_M1) phase_d = PH_R_DOWN;
            end
            PH_R_DOWN: begin
              r_d = r_q - ONE;
              if (r_q == ONE) phase_d = PH_B_UP;
            end
            PH_B_UP: begin
              b_d = b_q + ONE;
              if (b_q == DMAX_M1) phase_d = PH_G_DOWN;
            end
            PH_G_DOWN: begin
              g_d = g_q - ONE;
              if (g_q == ONE) phase_d = PH_R_UP;
            end
            PH_R_UP: begin
              r_d = r_q + ONE;
              if (r_q == DMAX_M1) phase_d = PH_B_DOWN;
            end
            PH_B_DOWN: begin
              b_d = b_q - ONE;
              if (b_q == ONE) phase_d = PH_G_UP;
            end
            default: phase_d = PH_G_UP;
          endcase
        end
        MODE_BREATHE: begin
          // All channels share one level; r_q is the reference.
          if (dir_up_q) begin
            r_d = r_q + ONE;
            if (r_q == DMAX_M1) dir_up_d = 1'b0;
          end else begin
            r_d = r_q - ONE;
            if (r_q == ONE) dir_up_d = 1'b1;
          end
          g_d = r_d;
          b_d = r_d;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_OFF;
      phase_q    <= PH_G_UP;
      dir_up_q   <= 1'b1;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      btn_prev_q <= 1'b0;
      primed_q   <= 1'b0;
      tick_q     <= 1'b0;
      step       <= 1'b0;
      duty_r     <= '0;
      duty_g     <= '0;
      duty_b     <= '0;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      dir_up_q   <= dir_up_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      btn_prev_q <= mode_btn;
      primed_q   <= 1'b1;
      tick_q     <= tick_take;
      step       <= tick_q;
`ifdef FADE_GAMMA_EN
      duty_r     <= gamma_lut(r_q);
      duty_g     <= gamma_lut(g_q);
      duty_b     <= gamma_lut(b_q);
`else
      duty_r     <= r_q;
      duty_g     <= g_q;
      duty_b     <= b_q;
`endif
    end
  end

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// tb/tb_rgb_fade_ctrl.sv - directed self-checking bench for rgb_fade_ctrl
module tb_rgb_fade_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_btn = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] duty_r, duty_g, duty_b;
  logic       step;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;

  rgb_fade_ctrl #(.TICK_DIV(4), .DUTY_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .mode_btn(mode_btn),
    .hold    (hold),
    .duty_r  (duty_r),
    .duty_g  (duty_g),
    .duty_b  (duty_b),
    .step    (step),
    .mode    (mode)
  );

  always #5 clk = ~clk;

`ifdef FADE_GAMMA_EN
  logic [3:0] gam [16] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3,
                           4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
  function automatic logic [3:0] exp_duty(input int lvl);
    return gam[lvl];
  endfunction
`else
  function automatic logic [3:0] exp_duty(input int lvl);
    return 4'(lvl);
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input int r, input int g, input int b);
    check({tag, ".r"}, 32'(duty_r), 32'(exp_duty(r)));
    check({tag, ".g"}, 32'(duty_g), 32'(exp_duty(g)));
    check({tag, ".b"}, 32'(duty_b), 32'(exp_duty(b)));
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    #1;
  endtask

  // Advance until step is seen (bounded); returns with the sample point just
  // after the edge that raised step.
  task automatic wait_steps(input int n, input string tag);
    int misses;
    bit got;
    misses = 0;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
        clk_cycle();
        if (step) got = 1'b1;
      end
      if (!got) misses++;
    end
    check({tag, ".step_timeout"}, 32'(misses), 32'd0);
  endtask

  task automatic press();
    mode_btn = 1'b1;
    clk_cycle();
    mode_btn = 1'b0;
    clk_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int changes;
    int steps_seen;
    int lvl;
    logic [3:0] hr, hg, hb;

    // Reset state
    clk_cycle();
    clk_cycle();
    check("rst.mode", 32'(mode), 32'd0);
    check("rst.step", 32'(step), 32'd0);
    check_rgb("rst", 0, 0, 0);
    reset = 1'b0;
    clk_cycle();

    // Enter WHEEL: mode now, duty one clock later, first tick after 4 more
    mode_btn = 1'b1;
    clk_cycle();
    mode_btn = 1'b0;
    check("wheel.mode", 32'(mode), 32'd1);
    check("wheel.latency_r", 32'(duty_r), 32'd0);
    clk_cycle();
    check_rgb("wheel.entry", 15, 0, 0);
    clk_cycle();
    clk_cycle();
    clk_cycle();
    check("wheel.no_step_early", 32'(step), 32'd0);
    check("wheel.g_before", 32'(duty_g), 32'(exp_duty(0)));
    clk_cycle();
    check("wheel.first_step", 32'(step), 32'd1);
    check_rgb("wheel.t1", 15, 1, 0);

    // Full wheel cycle waypoints
    wait_steps(14, "wheel.t15");
    check_rgb("wheel.t15", 15, 15, 0);
    wait_steps(15, "wheel.t30");
    check_rgb("wheel.t30", 0, 15, 0);
    wait_steps(15, "wheel.t45");
    check_rgb("wheel.t45", 0, 15, 15);
    wait_steps(15, "wheel.t60");
    check_rgb("wheel.t60", 0, 0, 15);
    wait_steps(15, "wheel.t75");
    check_rgb("wheel.t75", 15, 0, 15);
    wait_steps(15, "wheel.t90");
    check_rgb("wheel.t90", 15, 0, 0);
    wait_steps(1, "wheel.t91");
    check_rgb("wheel.t91_phase0", 15, 1, 0);

    // Hold for 20 clocks: frozen outputs, then tick resumes at count 1
    hr = duty_r; hg = duty_g; hb = duty_b;
    changes = 0;
    steps_seen = 0;
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clk_cycle();
      if (step) steps_seen++;
      if (duty_r !== hr || duty_g !== hg || duty_b !== hb) changes++;
    end
    hold = 1'b0;
    check("hold.steps", 32'(steps_seen), 32'd0);
    check("hold.duty_changes", 32'(changes), 32'd0);
    clk_cycle();
    clk_cycle();
    clk_cycle();
    check("hold.resume_early", 32'(step), 32'd0);
    clk_cycle();
    check("hold.resume_step", 32'(step), 32'd1);
    check_rgb("hold.resume", 15, 2, 0);

    // Mode edge coincides with a tick: edge wins, tick is dropped
    clk_cycle();
    clk_cycle();
    mode_btn = 1'b1;
    clk_cycle();
    mode_btn = 1'b0;
    check("edge_tick.mode", 32'(mode), 32'd2);
    check("edge_tick.step0", 32'(step), 32'd0);
    clk_cycle();
    check("edge_tick.step1", 32'(step), 32'd0);
    check_rgb("breathe.entry", 0, 0, 0);

    // BREATHE 31 ticks: 1..15, 14..0, then 1
    for (int k = 1; k <= 31; k++) begin
      wait_steps(1, "breathe");
      lvl = (k <= 15) ? k : ((k <= 30) ? 30 - k : 1);
      check_rgb($sformatf("breathe.t%0d", k), lvl, lvl, lvl);
    end

    // Reset mid-BREATHE takes effect without a clock edge
    wait_steps(3, "breathe.pre_rst");
    check("breathe.t34", 32'(duty_r), 32'(exp_duty(4)));
    #1;
    reset = 1'b1;
    #1;
    check("async_rst.mode", 32'(mode), 32'd0);
    check("async_rst.step", 32'(step), 32'd0);
    check_rgb("async_rst", 0, 0, 0);

    // Button held high through reset gives no advance
    mode_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    reset = 1'b0;
    clk_cycle();
    clk_cycle();
    clk_cycle();
    check("held_thru_rst.mode", 32'(mode), 32'd0);
    mode_btn = 1'b0;
    clk_cycle();

    // Holding the button for several clocks advances only once
    mode_btn = 1'b1;
    for (int i = 0; i < 5; i++) clk_cycle();
    mode_btn = 1'b0;
    clk_cycle();
    check("long_press.mode", 32'(mode), 32'd1);

    // Step through BREATHE, STATIC, OFF
    press();
    check("cycle.breathe", 32'(mode), 32'd2);
    press();
    check("cycle.static", 32'(mode), 32'd3);
    check_rgb("static", 15, 15, 15);
    press();
    check("cycle.off", 32'(mode), 32'd0);
    check_rgb("off", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
